// File: rtl/pipeline_pkg.sv
// Shared types and default field widths for the MIPS pipeline stage registers.
// The occupancy enum doubles as the externally visible entry count.
package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  localparam int DECODE_EXECUTE_CTRL_WIDTH   = 24;
  localparam int DECODE_EXECUTE_DATA_WIDTH   = 128;
  localparam int EXECUTE_MEMORY_CTRL_WIDTH   = 16;
  localparam int EXECUTE_MEMORY_DATA_WIDTH   = 96;
  localparam int MEMORY_WRITEBACK_CTRL_WIDTH = 8;
  localparam int MEMORY_WRITEBACK_DATA_WIDTH = 64;
  localparam int DEFAULT_STALL_CNT_WIDTH     = 16;

  // Bubbles must never carry live control bits.
  function automatic logic mask_is_live(input logic valid);
    return valid;
  endfunction

endpackage

// File: rtl/pipeline_entry.sv
// One {valid, ctrl, data} storage slot with load, drop and clear.
// Control is stored as zero whenever the slot holds no valid entry.
module pipeline_entry
  import pipeline_pkg::*;
#(
  parameter int CTRL_WIDTH = 24,
  parameter int DATA_WIDTH = 128,
  parameter int CLEAR_DATA = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic                  drop_i,
  input  logic                  valid_i,
  input  logic [CTRL_WIDTH-1:0] ctrl_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_q, valid_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state selection: clear beats load, load beats drop.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      if (CLEAR_DATA != 0) begin
        data_d = '0;
      end else begin
        data_d = data_q;
      end
    end else if (load_i) begin
      valid_d = valid_i;
      ctrl_d  = mask_is_live(valid_i) ? ctrl_i : '0;
      data_d  = data_i;
    end else if (drop_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (CLEAR_DATA != 0) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic valid/ready pipeline stage register with optional two-entry skid
// buffer, synchronous flush and a saturating stall counter.
module pipeline_stage_register
  import pipeline_pkg::*;
#(
  parameter int CTRL_WIDTH      = 24,
  parameter int DATA_WIDTH      = 128,
  parameter int SKID            = 1,
  parameter int CLEAR_DATA      = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_WIDTH-1:0]      out_ctrl,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  occ_state_e                 state_q, state_d;
  logic                       in_ready_q, in_ready_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

  logic                  in_fire, out_fire;
  logic                  main_load, main_drop, main_from_skid;
  logic                  skid_load, skid_clear;
  logic                  main_valid, skid_valid;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_data_in;
  logic                  main_valid_in;

  assign in_ready = (SKID != 0) ? in_ready_q : (~main_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // Occupancy FSM and entry steering; flush overrides normal traffic.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      skid_clear = 1'b1;
    end else if (SKID != 0) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d   = EMPTY;
            main_drop = 1'b1;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end else begin
      if (in_fire) begin
        state_d   = ONE;
        main_load = 1'b1;
      end else if (out_fire) begin
        state_d   = EMPTY;
        main_drop = 1'b1;
      end else begin
        state_d = state_q;
      end
    end
    in_ready_d = (state_d != FULL);
  end

  // Saturating stall counter; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (main_valid && !out_ready && (stall_q != {STALL_CNT_WIDTH{1'b1}})) begin
      stall_d = stall_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  assign main_valid_in = main_from_skid ? skid_valid : 1'b1;
  assign main_ctrl_in  = main_from_skid ? skid_ctrl  : in_ctrl;
  assign main_data_in  = main_from_skid ? skid_data  : in_data;

  pipeline_entry #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear_i (flush),
    .load_i  (main_load),
    .drop_i  (main_drop),
    .valid_i (main_valid_in),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  if (SKID != 0) begin : g_skid
    pipeline_entry #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .clear_i (skid_clear),
      .load_i  (skid_load),
      .drop_i  (1'b0),
      .valid_i (1'b1),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

  assign out_valid   = main_valid;
  assign out_ctrl    = main_valid ? main_ctrl : '0;
  assign out_data    = main_data;
  assign occupancy   = state_q;
  assign stall_count = stall_q;

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
Generic, parametrised pipeline stage register for the MIPS pipeline.
- Replaces hand-written per-stage register banks (decode/execute, execute/memory, ...) with one block.
- Carries a control field and a datapath field from stage N to stage N+1 under a valid/ready handshake.
- Uses an optional two-entry skid buffer, so stalls do not need a combinational ready path through the stage.
- Supports synchronous flush (bubble insertion) and counts stall cycles for performance debug.

Parameters:
CTRL_WIDTH, 24, width of control field; forced to zero whenever its entry is invalid or flushed.
DATA_WIDTH, 128, width of datapath field (operands, immediates, PC values).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CLEAR_DATA, 1, 1 = data field zeroed on reset/flush; 0 = data field keeps its value, only valid/ctrl are cleared.
STALL_CNT_WIDTH, 16, width of the saturating stall counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of all stored entries (branch/jump squash)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_ctrl  input  CTRL_WIDTH  upstream control bits
in_data  input  DATA_WIDTH  upstream datapath bits
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts the entry this cycle
out_ctrl  output  CTRL_WIDTH  stored control bits; 0 when out_valid=0
out_data  output  DATA_WIDTH  stored datapath bits
occupancy  output  2  entries held (0..2)
stall_count  output  STALL_CNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-high (reset). All state updates on the rising edge of clk.
  - Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0, skid entry invalid and zero. in_ready=1 (SKID=1) or 1 (SKID=0, because out_valid=0).
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Latency: 1 cycle from in_fire to out_valid. Sustained throughput: 1 entry/cycle.
- State (SKID=1), encoded as occupancy:
  - EMPTY: in_ready=1. in_fire -> ONE, with main entry <= in.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in.
    - in_fire & !out_fire -> FULL, skid <= in.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL: in_ready=0. out_fire -> ONE, main <= skid, skid cleared. Otherwise hold.
  - in_ready is a register output: in_ready = (next state != FULL).
- SKID=0:
  - No FULL state.
  - in_ready = !out_valid | out_ready (combinational).
  - Main entry is loaded on in_fire and invalidated on out_fire without in_fire.
- Entry ordering: strict FIFO. The skid entry is never presented before the main entry.
- Control masking:
  - The ctrl of an invalid entry is stored as 0.
  - out_ctrl is 0 whenever out_valid=0, so a bubble can never assert register/memory writes.
- Flush:
  - Priority: reset > flush > normal operation.
  - Flush clears both entries: valid=0, ctrl=0, data=0 if CLEAR_DATA=1; occupancy -> 0.
  - An in_fire in the same cycle as flush is dropped. An out_fire in the same cycle as flush still counts as consumed downstream.
  - in_ready is 1 in the cycle after flush.
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset; flush does not clear it.
- Data is never altered in flight; no width conversion.

Decomposition:
- Package pipeline_pkg holds:
  - the occupancy state enum (EMPTY=0, ONE=1, FULL=2);
  - default width constants for the MIPS stages (e.g. DECODE_EXECUTE_CTRL_WIDTH, DECODE_EXECUTE_DATA_WIDTH).
- One sub-module, pipeline_entry: a single {valid, ctrl, data} register with load, clear, and the CLEAR_DATA option. It is instantiated twice: main, and skid when SKID=1.

Test Plan:
- Reset asserted mid-stream while in FULL -> next cycle out_valid=0, occupancy=0, out_ctrl=0, stall_count=0, in_ready=1.
- Stream in_ctrl=0x000001, 0x000002, 0x000003 with out_ready=1 held -> out_ctrl shows 1, 2, 3 on consecutive cycles, each 1 cycle after input; occupancy stays 1.
- Backpressure, SKID=1: push A, B, C with out_ready=0 -> occupancy=2 after B, in_ready=0, C held upstream. Raise out_ready -> A, B, C delivered in order with no loss; stall_count equals the number of stalled cycles.
- Flush while FULL with simultaneous in_valid=1, in_data=0xDEAD -> next cycle out_valid=0, out_ctrl=0, occupancy=0. 0xDEAD never appears at the output.
- Hold out_valid=1, out_ready=0 for 70000 cycles with STALL_CNT_WIDTH=16 -> stall_count saturates at 0xFFFF and does not wrap. Flush leaves the value unchanged.
- SKID=0 build: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle and the entry is replaced with no bubble. With out_ready=0 -> in_ready=0.
